// File: rtl/vend_order_ctrl.sv
// vend_order_ctrl
//   Sequential front end for the combinational vendingmachine block. It collects
//   coins, an item selection and purchase/refund requests. It presents a
//   registered code/count/money triple to vendingmachine and samples its verdict.
//   It then sequences dispense, change and refund pulses to the mechanics.
//
// Optional feature: define VEND_TIMEOUT_EN to build an idle timeout in COLLECT.
//   The timeout refunds the credit and clears the selection.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   coin_valid, coin_amt[3:0]     coin insertion; a zero amount is ignored
//   sel_valid, sel_code, sel_count item selection (latest one wins)
//   confirm, cancel               purchase / refund requests (cancel wins)
//   vm_code, vm_count, vm_money   registered request to vendingmachine
//   vm_posibility, vm_remaining   verdict and change from vendingmachine
//   credit                        accumulated credit
//   busy                          high in EVAL / DISPENSE / CHANGE
//   coin_reject, nack             1-cycle pulses
//   dispense_valid/_code/_count   1-cycle dispense command
//   change_valid, change_amt      1-cycle change / refund command
//   state_dbg                     current FSM state encoding (debug)
//
// Output semantics: every *_valid / pulse output is high for exactly one clock.
// The data qualified by that pulse is meaningful only in that cycle and reads
// 0 otherwise. There is no back-pressure: the mechanics must accept each pulse
// on the cycle it is presented.
module vend_order_ctrl #(
    parameter int MAX_CREDIT     = 15,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [3:0] coin_amt,
    input  logic       sel_valid,
    input  logic [1:0] sel_code,
    input  logic [2:0] sel_count,
    input  logic       confirm,
    input  logic       cancel,
    output logic [1:0] vm_code,
    output logic [2:0] vm_count,
    output logic [3:0] vm_money,
    input  logic       vm_posibility,
    input  logic [3:0] vm_remaining,
    output logic [3:0] credit,
    output logic       busy,
    output logic       coin_reject,
    output logic       nack,
    output logic       dispense_valid,
    output logic [1:0] dispense_code,
    output logic [2:0] dispense_count,
    output logic       change_valid,
    output logic [3:0] change_amt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_EVAL     = 3'd2,
        S_DISPENSE = 3'd3,
        S_CHANGE   = 3'd4
    } state_t;

    // Elaboration-time parameter sanity checks.
    if (MAX_CREDIT < 1 || MAX_CREDIT > 15) begin : g_bad_credit
        $error("MAX_CREDIT must be in 1..15 to fit vm_money");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..2**TMO_W-1");
    end

    localparam logic [4:0] CREDIT_MAX = 5'(MAX_CREDIT);

    state_t     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic [1:0] sel_code_q, sel_code_d;
    logic [2:0] sel_count_q, sel_count_d;
    logic       sel_has_q, sel_has_d;
    logic [1:0] vm_code_q, vm_code_d;
    logic [2:0] vm_count_q, vm_count_d;
    logic [3:0] vm_money_q, vm_money_d;
    logic [3:0] rem_q, rem_d;
    logic       coin_reject_q, coin_reject_d;
    logic       nack_q, nack_d;
    logic       disp_v_q, disp_v_d;
    logic [1:0] disp_code_q, disp_code_d;
    logic [2:0] disp_count_q, disp_count_d;
    logic       chg_v_q, chg_v_d;
    logic [3:0] chg_amt_q, chg_amt_d;

    logic       busy_s;
    logic       coin_nz;
    logic [4:0] coin_sum;
    logic       coin_take;
    logic       tmo_hit;

    assign busy_s    = (state_q == S_EVAL) || (state_q == S_DISPENSE) || (state_q == S_CHANGE);
    assign coin_nz   = coin_valid && (coin_amt != 4'd0);
    // 5-bit sum so an over-ceiling coin is detected instead of wrapping.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_amt};
    assign coin_take = coin_nz && !busy_s && (coin_sum <= CREDIT_MAX);

`ifdef VEND_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             activity;

    assign activity = coin_valid | sel_valid | confirm | cancel;
    assign tmo_hit  = (state_q == S_COLLECT) && !activity &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside COLLECT, so entering COLLECT always starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != S_COLLECT || activity) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sel_code_d    = sel_code_q;
        sel_count_d   = sel_count_q;
        sel_has_d     = sel_has_q;
        vm_code_d     = vm_code_q;
        vm_count_d    = vm_count_q;
        vm_money_d    = vm_money_q;
        rem_d         = rem_q;
        coin_reject_d = 1'b0;
        nack_d        = 1'b0;
        disp_v_d      = 1'b0;
        disp_code_d   = 2'd0;
        disp_count_d  = 3'd0;
        chg_v_d       = 1'b0;
        chg_amt_d     = 4'd0;

        if (coin_take) begin
            credit_d = coin_sum[3:0];
        end else if (coin_nz) begin
            coin_reject_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (sel_valid) begin
                    sel_code_d  = sel_code;
                    sel_count_d = sel_count;
                    sel_has_d   = 1'b1;
                end
                if (state_q == S_IDLE) begin
                    if (coin_take || sel_valid) begin
                        state_d = S_COLLECT;
                    end
                end else if (cancel || tmo_hit) begin
                    // Refund includes a coin accepted in this same cycle.
                    state_d     = S_CHANGE;
                    chg_v_d     = (credit_d != 4'd0);
                    chg_amt_d   = credit_d;
                    credit_d    = 4'd0;
                    sel_has_d   = 1'b0;
                    sel_code_d  = 2'd0;
                    sel_count_d = 3'd0;
                end else if (confirm && sel_has_q && (sel_count_q != 3'd0)) begin
                    state_d    = S_EVAL;
                    vm_code_d  = sel_code_q;
                    vm_count_d = sel_count_q;
                    vm_money_d = credit_d;
                end
            end
            S_EVAL: begin
                rem_d = vm_remaining;
                if (vm_posibility) begin
                    state_d      = S_DISPENSE;
                    disp_v_d     = 1'b1;
                    disp_code_d  = vm_code_q;
                    disp_count_d = vm_count_q;
                end else begin
                    state_d = S_COLLECT;
                    nack_d  = 1'b1;
                end
            end
            S_DISPENSE: begin
                state_d     = S_CHANGE;
                chg_v_d     = (rem_q != 4'd0);
                chg_amt_d   = rem_q;
                credit_d    = 4'd0;
                sel_has_d   = 1'b0;
                sel_code_d  = 2'd0;
                sel_count_d = 3'd0;
            end
            S_CHANGE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= 4'd0;
            sel_code_q    <= 2'd0;
            sel_count_q   <= 3'd0;
            sel_has_q     <= 1'b0;
            vm_code_q     <= 2'd0;
            vm_count_q    <= 3'd0;
            vm_money_q    <= 4'd0;
            rem_q         <= 4'd0;
            coin_reject_q <= 1'b0;
            nack_q        <= 1'b0;
            disp_v_q      <= 1'b0;
            disp_code_q   <= 2'd0;
            disp_count_q  <= 3'd0;
            chg_v_q       <= 1'b0;
            chg_amt_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_code_q    <= sel_code_d;
            sel_count_q   <= sel_count_d;
            sel_has_q     <= sel_has_d;
            vm_code_q     <= vm_code_d;
            vm_count_q    <= vm_count_d;
            vm_money_q    <= vm_money_d;
            rem_q         <= rem_d;
            coin_reject_q <= coin_reject_d;
            nack_q        <= nack_d;
            disp_v_q      <= disp_v_d;
            disp_code_q   <= disp_code_d;
            disp_count_q  <= disp_count_d;
            chg_v_q       <= chg_v_d;
            chg_amt_q     <= chg_amt_d;
        end
    end

    assign vm_code        = vm_code_q;
    assign vm_count       = vm_count_q;
    assign vm_money       = vm_money_q;
    assign credit         = credit_q;
    assign busy           = busy_s;
    assign coin_reject    = coin_reject_q;
    assign nack           = nack_q;
    assign dispense_valid = disp_v_q;
    assign dispense_code  = disp_code_q;
    assign dispense_count = disp_count_q;
    assign change_valid   = chg_v_q;
    assign change_amt     = chg_amt_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_vend_order_ctrl.sv
// Testbench for vend_order_ctrl. vm_posibility / vm_remaining come from a stub
// (stub_pos / stub_rem) set by each scenario. Pulse outputs are checked
// against a queue of expected events.
module tb_vend_order_ctrl;

    localparam logic [3:0] K_REJ  = 4'd1;
    localparam logic [3:0] K_NACK = 4'd2;
    localparam logic [3:0] K_DISP = 4'd3;
    localparam logic [3:0] K_CHG  = 4'd4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_COLLECT  = 3'd1;
    localparam logic [2:0] ST_EVAL     = 3'd2;
    localparam logic [2:0] ST_DISPENSE = 3'd3;
    localparam logic [2:0] ST_CHANGE   = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_amt = 4'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_code = 2'd0;
    logic [2:0] sel_count = 3'd0;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic       stub_pos = 1'b0;
    logic [3:0] stub_rem = 4'd0;
    logic [1:0] vm_code;
    logic [2:0] vm_count;
    logic [3:0] vm_money;
    logic [3:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       nack;
    logic       dispense_valid;
    logic [1:0] dispense_code;
    logic [2:0] dispense_count;
    logic       change_valid;
    logic [3:0] change_amt;
    logic [2:0] state_dbg;

    logic [29:0] all_outs;
    assign all_outs = {vm_code, vm_count, vm_money, credit, busy, coin_reject, nack,
                       dispense_valid, dispense_code, dispense_count, change_valid,
                       change_amt, state_dbg};

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];
    logic [12:0] act_list[$];
    logic [12:0] exp_ev;

    vend_order_ctrl #(.MAX_CREDIT(15), .TIMEOUT_CYCLES(8), .TMO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_amt(coin_amt),
        .sel_valid(sel_valid), .sel_code(sel_code), .sel_count(sel_count),
        .confirm(confirm), .cancel(cancel),
        .vm_code(vm_code), .vm_count(vm_count), .vm_money(vm_money),
        .vm_posibility(stub_pos), .vm_remaining(stub_rem),
        .credit(credit), .busy(busy), .coin_reject(coin_reject), .nack(nack),
        .dispense_valid(dispense_valid), .dispense_code(dispense_code),
        .dispense_count(dispense_count), .change_valid(change_valid),
        .change_amt(change_amt), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [12:0] ev(input logic [3:0] kind, input logic [1:0] code,
                                       input logic [2:0] cnt, input logic [3:0] amt);
        return {kind, code, cnt, amt};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            act_list.delete();
            if (coin_reject)    act_list.push_back(ev(K_REJ, 2'd0, 3'd0, 4'd0));
            if (nack)           act_list.push_back(ev(K_NACK, 2'd0, 3'd0, 4'd0));
            if (dispense_valid) act_list.push_back(ev(K_DISP, dispense_code, dispense_count, 4'd0));
            if (change_valid)   act_list.push_back(ev(K_CHG, 2'd0, 3'd0, change_amt));
            if (nack || dispense_valid || change_valid) begin
                checks++;
                if ($countones({nack, dispense_valid, change_valid}) > 1) begin
                    errors++;
                    $display("FAIL pulse_exclusive nack=%b disp=%b chg=%b required at most one",
                             nack, dispense_valid, change_valid);
                end
            end
            foreach (act_list[i]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse got=%h required=none", act_list[i]);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (act_list[i] !== exp_ev) begin
                        errors++;
                        $display("FAIL scoreboard got=%h required=%h", act_list[i], exp_ev);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coin(input logic [3:0] amt);
        coin_valid = 1'b1;
        coin_amt   = amt;
        tick();
        coin_valid = 1'b0;
        coin_amt   = 4'd0;
    endtask

    task automatic drive_sel(input logic [1:0] code, input logic [2:0] cnt);
        sel_valid = 1'b1;
        sel_code  = code;
        sel_count = cnt;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic drive_confirm();
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
    endtask

    task automatic drive_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs !== 30'd0) begin
            errors++; $display("FAIL reset_outputs got=%h required=0", all_outs);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL reset_state got=%0d required=%0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_coins();
        drive_coin(4'd10);
        checks++;
        if (credit !== 4'd10 || state_dbg !== ST_COLLECT) begin
            errors++; $display("FAIL coin_10 credit=%0d state=%0d required 10/1", credit, state_dbg);
        end
        drive_coin(4'd5);
        checks++;
        if (credit !== 4'd15) begin
            errors++; $display("FAIL coin_15 credit=%0d required=15", credit);
        end
        exp_q.push_back(ev(K_REJ, 2'd0, 3'd0, 4'd0));
        drive_coin(4'd1);
        drive_coin(4'd0);
        tick();
        checks++;
        if (credit !== 4'd15) begin
            errors++; $display("FAIL coin_over credit=%0d required=15", credit);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL coin_pending got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_dispense();
        drive_sel(2'b10, 3'd1);
        stub_pos = 1'b1;
        stub_rem = 4'd7;
        exp_q.push_back(ev(K_DISP, 2'b10, 3'd1, 4'd0));
        exp_q.push_back(ev(K_CHG, 2'd0, 3'd0, 4'd7));
        drive_confirm();
        checks++;
        if (state_dbg !== ST_EVAL || vm_code !== 2'b10 || vm_count !== 3'd1 ||
            vm_money !== 4'd15 || busy !== 1'b1) begin
            errors++;
            $display("FAIL eval_vm state=%0d code=%0d count=%0d money=%0d busy=%b required 2/2/1/15/1",
                     state_dbg, vm_code, vm_count, vm_money, busy);
        end
        tick();
        checks++;
        if (state_dbg !== ST_DISPENSE) begin
            errors++; $display("FAIL dispense_state got=%0d required=%0d", state_dbg, ST_DISPENSE);
        end
        tick();
        checks++;
        if (state_dbg !== ST_CHANGE) begin
            errors++; $display("FAIL change_state got=%0d required=%0d", state_dbg, ST_CHANGE);
        end
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || credit !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL after_buy state=%0d credit=%0d busy=%b required 0/0/0",
                               state_dbg, credit, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL dispense_pending got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_nack_cancel();
        drive_coin(4'd10);
        drive_coin(4'd5);
        drive_sel(2'b01, 3'd1);
        stub_pos = 1'b0;
        stub_rem = 4'd3;
        exp_q.push_back(ev(K_NACK, 2'd0, 3'd0, 4'd0));
        drive_confirm();
        tick();
        checks++;
        if (state_dbg !== ST_COLLECT || credit !== 4'd15 || busy !== 1'b0) begin
            errors++; $display("FAIL nack_collect state=%0d credit=%0d busy=%b required 1/15/0",
                               state_dbg, credit, busy);
        end
        exp_q.push_back(ev(K_CHG, 2'd0, 3'd0, 4'd15));
        drive_cancel();
        checks++;
        if (state_dbg !== ST_CHANGE || credit !== 4'd0) begin
            errors++; $display("FAIL cancel_change state=%0d credit=%0d required 4/0", state_dbg, credit);
        end
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || exp_q.size() != 0) begin
            errors++; $display("FAIL cancel_idle state=%0d pending=%0d required 0/0",
                               state_dbg, exp_q.size());
        end
    endtask

    task automatic test_cancel_priority();
        drive_coin(4'd4);
        drive_sel(2'b00, 3'd2);
        exp_q.push_back(ev(K_CHG, 2'd0, 3'd0, 4'd4));
        confirm = 1'b1;
        cancel  = 1'b1;
        tick();
        confirm = 1'b0;
        cancel  = 1'b0;
        checks++;
        if (state_dbg !== ST_CHANGE) begin
            errors++; $display("FAIL cancel_priority state=%0d required=%0d", state_dbg, ST_CHANGE);
        end
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || exp_q.size() != 0) begin
            errors++; $display("FAIL priority_idle state=%0d pending=%0d required 0/0",
                               state_dbg, exp_q.size());
        end
    endtask

    task automatic test_busy_coin();
        drive_coin(4'd3);
        drive_sel(2'b11, 3'd1);
        stub_pos = 1'b1;
        stub_rem = 4'd0;
        exp_q.push_back(ev(K_REJ, 2'd0, 3'd0, 4'd0));
        exp_q.push_back(ev(K_DISP, 2'b11, 3'd1, 4'd0));
        drive_confirm();
        checks++;
        if (vm_money !== 4'd3) begin
            errors++; $display("FAIL busy_vm_money got=%0d required=3", vm_money);
        end
        drive_coin(4'd2);
        checks++;
        if (credit !== 4'd3 || state_dbg !== ST_DISPENSE) begin
            errors++; $display("FAIL busy_coin credit=%0d state=%0d required 3/3", credit, state_dbg);
        end
        tick();
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || credit !== 4'd0 || exp_q.size() != 0) begin
            errors++; $display("FAIL busy_end state=%0d credit=%0d pending=%0d required 0/0/0",
                               state_dbg, credit, exp_q.size());
        end
    endtask

    task automatic test_confirm_ignored();
        drive_cancel();
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL idle_cancel state=%0d required=0", state_dbg);
        end
        drive_coin(4'd6);
        drive_confirm();
        checks++;
        if (state_dbg !== ST_COLLECT) begin
            errors++; $display("FAIL confirm_nosel state=%0d required=1", state_dbg);
        end
        drive_sel(2'b10, 3'd0);
        drive_confirm();
        checks++;
        if (state_dbg !== ST_COLLECT) begin
            errors++; $display("FAIL confirm_cnt0 state=%0d required=1", state_dbg);
        end
        exp_q.push_back(ev(K_CHG, 2'd0, 3'd0, 4'd6));
        drive_cancel();
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || exp_q.size() != 0) begin
            errors++; $display("FAIL ignored_end state=%0d pending=%0d required 0/0",
                               state_dbg, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        drive_coin(4'd9);
        checks++;
        if (credit !== 4'd9) begin
            errors++; $display("FAIL mid_credit got=%0d required=9", credit);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== 30'd0) begin
            errors++; $display("FAIL mid_reset_outputs got=%h required=0", all_outs);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (state_dbg !== ST_IDLE || credit !== 4'd0) begin
            errors++; $display("FAIL mid_reset_idle state=%0d credit=%0d required 0/0", state_dbg, credit);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] amt;
        logic [1:0] code;
        logic [2:0] cnt;
        logic [3:0] rem;
        for (int i = 0; i < 4; i++) begin
            amt  = 4'($urandom_range(1, 15));
            code = 2'($urandom_range(0, 3));
            cnt  = 3'($urandom_range(1, 7));
            rem  = 4'($urandom_range(0, int'(amt)));
            drive_coin(amt);
            drive_sel(code, cnt);
            stub_pos = 1'b1;
            stub_rem = rem;
            exp_q.push_back(ev(K_DISP, code, cnt, 4'd0));
            if (rem != 4'd0) exp_q.push_back(ev(K_CHG, 2'd0, 3'd0, rem));
            drive_confirm();
            checks++;
            if (vm_money !== amt || vm_code !== code || vm_count !== cnt) begin
                errors++; $display("FAIL b2b_vm money=%0d code=%0d count=%0d required %0d/%0d/%0d",
                                   vm_money, vm_code, vm_count, amt, code, cnt);
            end
            repeat (3) tick();
            checks++;
            if (state_dbg !== ST_IDLE || credit !== 4'd0 || exp_q.size() != 0) begin
                errors++; $display("FAIL b2b_end state=%0d credit=%0d pending=%0d required 0/0/0",
                                   state_dbg, credit, exp_q.size());
            end
        end
    endtask

    task automatic test_timeout();
        drive_coin(4'd5);
`ifdef VEND_TIMEOUT_EN
        exp_q.push_back(ev(K_CHG, 2'd0, 3'd0, 4'd5));
        repeat (7) tick();
        checks++;
        if (state_dbg !== ST_COLLECT) begin
            errors++; $display("FAIL tmo_early state=%0d required=1", state_dbg);
        end
        tick();
        checks++;
        if (state_dbg !== ST_CHANGE) begin
            errors++; $display("FAIL tmo_fire state=%0d required=4", state_dbg);
        end
        tick();
`else
        repeat (300) tick();
        checks++;
        if (state_dbg !== ST_COLLECT || credit !== 4'd5) begin
            errors++; $display("FAIL no_timeout state=%0d credit=%0d required 1/5", state_dbg, credit);
        end
        exp_q.push_back(ev(K_CHG, 2'd0, 3'd0, 4'd5));
        drive_cancel();
        tick();
`endif
        checks++;
        if (state_dbg !== ST_IDLE || exp_q.size() != 0) begin
            errors++; $display("FAIL tmo_end state=%0d pending=%0d required 0/0", state_dbg, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_coins();
        test_dispense();
        test_nack_cancel();
        test_cancel_priority();
        test_busy_coin();
        test_confirm_ignored();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL final_pending got=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
